// File: rtl/fetch_stage.sv
// LC-3b pipeline fetch stage: PC, imem read handshake, one-entry skid buffer and IF/ID register.
// Define IFETCH_ALIGN_CHECK_EN to fault on odd redirect targets instead of silently aligning them.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_read,
    output logic [15:0] imem_address,
    input  logic [15:0] imem_rdata,
    input  logic        imem_resp,
    output logic        if_valid,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus2,
    output logic [15:0] if_ir,
    output logic [3:0]  opcode,
    output logic        imm_check,
    output logic        jsr_check,
    output logic        rshf_check,
    output logic        if_fault
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_PEND,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] drain_addr_q, drain_addr_d;
    logic        if_valid_q, if_valid_d;
    logic [15:0] if_pc_q, if_pc_d;
    logic [15:0] if_ir_q, if_ir_d;
    logic        skid_valid_q, skid_valid_d;
    logic [15:0] skid_pc_q, skid_pc_d;
    logic [15:0] skid_ir_q, skid_ir_d;
    logic        fault_q;
    logic [15:0] redirect_tgt;
    logic        read_req;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic fault_d;

    assign redirect_tgt = redirect_pc;

    always_comb begin
        fault_d = fault_q;
        if (redirect) begin
            fault_d = redirect_pc[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    assign redirect_tgt = redirect_pc & 16'hFFFE;
    assign fault_q      = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_ir_d      = if_ir_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_ir_d    = skid_ir_q;
        read_req     = 1'b0;
        imem_address = pc_q;

        // DRAIN keeps presenting the abandoned address: a request may not be withdrawn.
        unique case (state_q)
            S_FETCH: read_req = !fault_q;
            S_PEND:  read_req = 1'b0;
            S_DRAIN: begin
                read_req     = 1'b1;
                imem_address = drain_addr_q;
            end
            default: read_req = 1'b0;
        endcase

        if (redirect) begin
            pc_d         = redirect_tgt;
            if_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
            if (read_req && !imem_resp) begin
                state_d = S_DRAIN;
                if (state_q == S_FETCH) begin
                    drain_addr_d = pc_q;
                end
            end else begin
                state_d = S_FETCH;
            end
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (read_req && imem_resp) begin
                        pc_d = pc_q + 16'd2;
                        if (stall_in) begin
                            skid_valid_d = 1'b1;
                            skid_pc_d    = pc_q;
                            skid_ir_d    = imem_rdata;
                            state_d      = S_PEND;
                        end else begin
                            if_valid_d = 1'b1;
                            if_pc_d    = pc_q;
                            if_ir_d    = imem_rdata;
                        end
                    end else if (!stall_in) begin
                        if_valid_d = 1'b0;
                    end
                end
                S_PEND: begin
                    if (!stall_in) begin
                        if_valid_d   = skid_valid_q;
                        if_pc_d      = skid_pc_q;
                        if_ir_d      = skid_ir_q;
                        skid_valid_d = 1'b0;
                        state_d      = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem_resp) begin
                        state_d = S_FETCH;
                    end
                    if (!stall_in) begin
                        if_valid_d = 1'b0;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            if_ir_q      <= '0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_ir_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_ir_q      <= if_ir_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_ir_q    <= skid_ir_d;
        end
    end

    assign imem_read   = read_req;
    assign if_valid    = if_valid_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus2 = if_pc_q + 16'd2;
    assign if_ir       = if_ir_q;
    assign opcode      = if_ir_q[15:12];
    assign imm_check   = if_ir_q[5];
    assign jsr_check   = if_ir_q[11];
    assign rshf_check  = if_ir_q[4];
    assign if_fault    = fault_q;

endmodule
